// File: rtl/updsl_phy_to_llr_gen.sv
// Uplink slow-PHY to LLR formatter: unpacks IQ and noise FIFO words
// into OUT_RE-lane beats behind a valid/ready output slot.
module updsl_phy_to_llr_gen #(
   parameter int DW             = 16,
   parameter int IQ_RE_PER_WORD = 4,
   parameter int NOISE_PER_WORD = 8,
   parameter int OUT_RE         = 2
) (
   input  logic                             i_core_clk,
   input  logic                             i_rx_rst,
   input  logic                             i_start,
   input  logic [15:0]                      i_user_iq_noise_rate,
   input  logic [15:0]                      i_cur_user_re_amounts,
   input  logic [2*IQ_RE_PER_WORD*DW-1:0]   i_iq_fifo_data,
   input  logic                             i_iq_fifo_empty,
   output logic                             o_iq_fifo_rd_en,
   input  logic [NOISE_PER_WORD*DW-1:0]     i_noise_fifo_data,
   input  logic                             i_noise_fifo_empty,
   output logic                             o_noise_fifo_rd_en,
   input  logic                             i_llr_ready,
   output logic                             o_data_strobe,
   output logic [OUT_RE*DW-1:0]             o_re_data_i,
   output logic [OUT_RE*DW-1:0]             o_re_data_q,
   output logic [OUT_RE*DW-1:0]             o_noise_data,
   output logic [OUT_RE-1:0]                o_re_valid,
   output logic                             o_last,
   output logic                             o_busy,
   output logic                             o_done,
   output logic                             o_err
);

   localparam int IQ_LW = (IQ_RE_PER_WORD > 1) ? $clog2(IQ_RE_PER_WORD) : 1;
   localparam int NZ_LW = (NOISE_PER_WORD > 1) ? $clog2(NOISE_PER_WORD) : 1;
   localparam logic [15:0] STEP   = 16'(OUT_RE);
   localparam logic [15:0] IQ_END = 16'(IQ_RE_PER_WORD);
   localparam logic [15:0] NZ_END = 16'(NOISE_PER_WORD);

   if ((IQ_RE_PER_WORD % OUT_RE) != 0 || (NOISE_PER_WORD % OUT_RE) != 0) begin : g_bad_cfg
      $error("OUT_RE must divide IQ_RE_PER_WORD and NOISE_PER_WORD");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t                 state_q, state_d;
   logic [15:0]            rate_q, rate_d;
   logic [15:0]            n_q, n_d;
   logic [15:0]            re_idx_q, re_idx_d;
   logic [15:0]            iq_lane_q, iq_lane_d;
   logic [15:0]            noise_lane_q, noise_lane_d;
   logic [15:0]            noise_sub_q, noise_sub_d;
   logic                   strobe_q, strobe_d;
   logic [OUT_RE*DW-1:0]   out_i_q, out_i_d;
   logic [OUT_RE*DW-1:0]   out_q_q, out_q_d;
   logic [OUT_RE*DW-1:0]   out_n_q, out_n_d;
   logic [OUT_RE-1:0]      vld_q, vld_d;
   logic                   last_q, last_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;

   logic [DW-1:0]          w_i [IQ_RE_PER_WORD];
   logic [DW-1:0]          w_q [IQ_RE_PER_WORD];
   logic [DW-1:0]          w_n [NOISE_PER_WORD];
   logic [OUT_RE*DW-1:0]   lane_i, lane_q, lane_n;
   logic [OUT_RE-1:0]      lane_v;
   logic [15:0]            nz_lane_c, nz_sub_c, iq_nxt;
   logic [16:0]            re_end;
   logic                   free, gen, final_beat, iq_wrap, nz_wrap;

   always_comb begin
      for (int k = 0; k < IQ_RE_PER_WORD; k++) begin
         w_i[k] = i_iq_fifo_data[2*k*DW +: DW];
         w_q[k] = i_iq_fifo_data[(2*k+1)*DW +: DW];
      end
      for (int k = 0; k < NOISE_PER_WORD; k++) begin
         w_n[k] = i_noise_fifo_data[k*DW +: DW];
      end
   end

   // Noise lane/sub walk one RE at a time across the beat; the end
   // point becomes the next beat's starting position.
   always_comb begin
      lane_i    = '0;
      lane_q    = '0;
      lane_n    = '0;
      lane_v    = '0;
      nz_lane_c = noise_lane_q;
      nz_sub_c  = noise_sub_q;
      for (int j = 0; j < OUT_RE; j++) begin
         lane_v[j] = (17'(re_idx_q) + 17'(j)) < 17'(n_q);
         if (lane_v[j]) begin
            lane_i[j*DW +: DW] = w_i[iq_lane_q[IQ_LW-1:0] + IQ_LW'(j)];
            lane_q[j*DW +: DW] = w_q[iq_lane_q[IQ_LW-1:0] + IQ_LW'(j)];
            lane_n[j*DW +: DW] = w_n[nz_lane_c[NZ_LW-1:0]];
         end
         if (nz_sub_c + 16'd1 == rate_q) begin
            nz_sub_c  = '0;
            nz_lane_c = nz_lane_c + 16'd1;
         end else begin
            nz_sub_c  = nz_sub_c + 16'd1;
         end
      end
   end

   always_comb begin
      free       = !strobe_q || i_llr_ready;
      gen        = !i_rx_rst && (state_q == S_RUN) && free &&
                   !i_iq_fifo_empty && !i_noise_fifo_empty;
      re_end     = 17'(re_idx_q) + 17'(OUT_RE);
      final_beat = re_end >= 17'(n_q);
      iq_nxt     = iq_lane_q + STEP;
      iq_wrap    = iq_nxt == IQ_END;
      nz_wrap    = nz_lane_c == NZ_END;

      o_iq_fifo_rd_en    = gen && (iq_wrap || final_beat);
      o_noise_fifo_rd_en = gen && (nz_wrap || final_beat);

      state_d      = state_q;
      rate_d       = rate_q;
      n_d          = n_q;
      re_idx_d     = re_idx_q;
      iq_lane_d    = iq_lane_q;
      noise_lane_d = noise_lane_q;
      noise_sub_d  = noise_sub_q;
      out_i_d      = out_i_q;
      out_q_d      = out_q_q;
      out_n_d      = out_n_q;
      vld_d        = vld_q;
      last_d       = last_q;
      strobe_d     = gen ? 1'b1 : (i_llr_ready ? 1'b0 : strobe_q);
      done_d       = (state_q == S_DRAIN) && strobe_q && i_llr_ready;
      err_d        = i_start && ((state_q != S_IDLE) ||
                                 (i_user_iq_noise_rate == '0) ||
                                 (i_cur_user_re_amounts == '0));

      unique case (state_q)
         S_IDLE: begin
            if (i_start && i_user_iq_noise_rate != '0 &&
                i_cur_user_re_amounts != '0) begin
               state_d      = S_RUN;
               rate_d       = i_user_iq_noise_rate;
               n_d          = i_cur_user_re_amounts;
               re_idx_d     = '0;
               iq_lane_d    = '0;
               noise_lane_d = '0;
               noise_sub_d  = '0;
            end
         end
         S_RUN: begin
            if (gen) begin
               re_idx_d     = re_end[15:0];
               iq_lane_d    = iq_wrap ? '0 : iq_nxt;
               noise_lane_d = nz_wrap ? '0 : nz_lane_c;
               noise_sub_d  = nz_sub_c;
               if (final_beat) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (strobe_q && i_llr_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (gen) begin
         out_i_d = lane_i;
         out_q_d = lane_q;
         out_n_d = lane_n;
         vld_d   = lane_v;
         last_d  = final_beat;
      end
   end

   always_ff @(posedge i_core_clk) begin
      if (i_rx_rst) begin
         state_q      <= S_IDLE;
         rate_q       <= '0;
         n_q          <= '0;
         re_idx_q     <= '0;
         iq_lane_q    <= '0;
         noise_lane_q <= '0;
         noise_sub_q  <= '0;
         strobe_q     <= 1'b0;
         out_i_q      <= '0;
         out_q_q      <= '0;
         out_n_q      <= '0;
         vld_q        <= '0;
         last_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         rate_q       <= rate_d;
         n_q          <= n_d;
         re_idx_q     <= re_idx_d;
         iq_lane_q    <= iq_lane_d;
         noise_lane_q <= noise_lane_d;
         noise_sub_q  <= noise_sub_d;
         strobe_q     <= strobe_d;
         out_i_q      <= out_i_d;
         out_q_q      <= out_q_d;
         out_n_q      <= out_n_d;
         vld_q        <= vld_d;
         last_q       <= last_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign o_data_strobe = strobe_q;
   assign o_re_data_i   = out_i_q;
   assign o_re_data_q   = out_q_q;
   assign o_noise_data  = out_n_q;
   assign o_re_valid    = vld_q;
   assign o_last        = last_q;
   assign o_busy        = (state_q != S_IDLE);
   assign o_done        = done_q;
   assign o_err         = err_q;

endmodule
